brc_iter: RTL

- Parametrised, multi-cycle successor to the single-cycle branch comparator `brc`.
- Compares two WIDTH-bit operands CHUNK bits per cycle, starting at the MSB chunk.
- Resolves signed/unsigned less-than, equality and a funct3-selected branch-taken flag, with valid/ready handshakes on both sides.
- Used where a full-width combinational compare would limit Fmax, or for WIDTH=64 datapaths.

---
 rtl/brc_iter.sv | 277 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/brc_iter.sv
// -----------------------------------------------------------------------------
// brc_iter -- multi-cycle branch comparator
//
// Compares two WIDTH-bit operands CHUNK bits per cycle, starting from the most
// significant chunk. It produces a less-than flag (signed or unsigned), an
// equality flag and a RISC-V funct3-selected branch-taken flag. Requests and
// results use valid/ready handshakes. One request is in flight at a time.
//
// Configuration macro: BRC_ITER_EARLY_EXIT_EN
//   defined   : the compare stops at the first differing chunk
//               (latency 1..NCHUNK cycles).
//   undefined : the compare always walks all NCHUNK chunks. A sticky "decided"
//               flag freezes the ordering at the first differing chunk, so the
//               results are identical to the defined case and the latency is
//               a constant NCHUNK cycles.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  block idle and able to accept a request
//   rs1_data   in   operand A (WIDTH bits)
//   rs2_data   in   operand B (WIDTH bits)
//   br_un      in   1 = unsigned compare, 0 = signed two's complement
//   br_op      in   branch funct3
//   out_valid  out  result valid
//   out_ready  in   consumer accepts the result
//   br_less    out  A < B under the selected signedness
//   br_equal   out  A == B
//   br_taken   out  branch condition selected by br_op
// -----------------------------------------------------------------------------
module brc_iter #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic             br_un,
    input  logic [2:0]       br_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             br_less,
    output logic             br_equal,
    output logic             br_taken
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [IDXW-1:0] ZERO_IDX = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMP  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flipping the sign bit of the top chunk maps two's-complement order onto
    // unsigned order, so one unsigned comparator serves both modes.
    function automatic logic [CHUNK-1:0] order_key_f(
        input logic [CHUNK-1:0] chunk,
        input logic             flip_msb
    );
        logic [CHUNK-1:0] key;
        key = chunk;
        if (flip_msb) begin
            key[CHUNK-1] = ~chunk[CHUNK-1];
        end else begin
            key = chunk;
        end
        return key;
    endfunction

    // funct3 decode. The signedness comes from br_un alone, so BLT/BLTU share
    // a path, and so do BGE/BGEU.
    function automatic logic taken_f(
        input logic [2:0] op,
        input logic       less,
        input logic       equal
    );
        logic taken;
        case (op)
            3'b000:         taken = equal;
            3'b001:         taken = ~equal;
            3'b100, 3'b110: taken = less;
            3'b101, 3'b111: taken = ~less;
            default:        taken = 1'b0;
        endcase
        return taken;
    endfunction

    state_t state_r, state_nxt_s;

    logic [IDXW-1:0]  idx_r, idx_nxt_s;
    logic [WIDTH-1:0] a_r, a_nxt_s;
    logic [WIDTH-1:0] b_r, b_nxt_s;
    logic             un_r, un_nxt_s;
    logic [2:0]       op_r, op_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic             br_less_r, less_nxt_s;
    logic             br_equal_r, equal_nxt_s;
    logic             br_taken_r, taken_nxt_s;

`ifndef BRC_ITER_EARLY_EXIT_EN
    // Sticky ordering for the full-length walk.
    logic decided_r, decided_nxt_s;
    logic pend_less_r, pend_less_nxt_s;
    logic decided_eff_s, less_eff_s;
`endif

    logic [CHUNK-1:0] a_chunks_s [NCHUNK];
    logic [CHUNK-1:0] b_chunks_s [NCHUNK];
    logic [CHUNK-1:0] key_a_s, key_b_s;
    logic             chunk_diff_s, chunk_lt_s;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chunk
        assign a_chunks_s[g] = a_r[g*CHUNK +: CHUNK];
        assign b_chunks_s[g] = b_r[g*CHUNK +: CHUNK];
    end

    // Ordering keys and compare result for the chunk currently selected.
    always_comb begin
        key_a_s      = order_key_f(a_chunks_s[idx_r], (idx_r == LAST_IDX) && !un_r);
        key_b_s      = order_key_f(b_chunks_s[idx_r], (idx_r == LAST_IDX) && !un_r);
        chunk_diff_s = (key_a_s != key_b_s);
        chunk_lt_s   = (key_a_s < key_b_s);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state, datapath and result logic.
    always_comb begin
        state_nxt_s     = state_r;
        idx_nxt_s       = idx_r;
        a_nxt_s         = a_r;
        b_nxt_s         = b_r;
        un_nxt_s        = un_r;
        op_nxt_s        = op_r;
        out_valid_nxt_s = out_valid_r;
        less_nxt_s      = br_less_r;
        equal_nxt_s     = br_equal_r;
        taken_nxt_s     = br_taken_r;
`ifndef BRC_ITER_EARLY_EXIT_EN
        decided_nxt_s   = decided_r;
        pend_less_nxt_s = pend_less_r;
        decided_eff_s   = decided_r;
        less_eff_s      = pend_less_r;
`endif

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    a_nxt_s     = rs1_data;
                    b_nxt_s     = rs2_data;
                    un_nxt_s    = br_un;
                    op_nxt_s    = br_op;
                    idx_nxt_s   = LAST_IDX;
                    state_nxt_s = ST_CMP;
`ifndef BRC_ITER_EARLY_EXIT_EN
                    decided_nxt_s   = 1'b0;
                    pend_less_nxt_s = 1'b0;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end

            ST_CMP: begin
`ifdef BRC_ITER_EARLY_EXIT_EN
                if (chunk_diff_s) begin
                    state_nxt_s     = ST_DONE;
                    out_valid_nxt_s = 1'b1;
                    less_nxt_s      = chunk_lt_s;
                    equal_nxt_s     = 1'b0;
                    taken_nxt_s     = taken_f(op_r, chunk_lt_s, 1'b0);
                end else if (idx_r == ZERO_IDX) begin
                    state_nxt_s     = ST_DONE;
                    out_valid_nxt_s = 1'b1;
                    less_nxt_s      = 1'b0;
                    equal_nxt_s     = 1'b1;
                    taken_nxt_s     = taken_f(op_r, 1'b0, 1'b1);
                end else begin
                    idx_nxt_s = idx_r - ONE_IDX;
                end
`else
                // Only the first differing chunk from the top sets the order.
                if (!decided_r && chunk_diff_s) begin
                    decided_eff_s = 1'b1;
                    less_eff_s    = chunk_lt_s;
                end else begin
                    decided_eff_s = decided_r;
                    less_eff_s    = pend_less_r;
                end

                if (idx_r == ZERO_IDX) begin
                    state_nxt_s     = ST_DONE;
                    out_valid_nxt_s = 1'b1;
                    less_nxt_s      = less_eff_s;
                    equal_nxt_s     = ~decided_eff_s;
                    taken_nxt_s     = taken_f(op_r, less_eff_s, ~decided_eff_s);
                end else begin
                    idx_nxt_s       = idx_r - ONE_IDX;
                    decided_nxt_s   = decided_eff_s;
                    pend_less_nxt_s = less_eff_s;
                end
`endif
            end

            ST_DONE: begin
                if (out_ready) begin
                    out_valid_nxt_s = 1'b0;
                    state_nxt_s     = ST_IDLE;
                end else begin
                    out_valid_nxt_s = 1'b1;
                end
            end

            default: begin
                state_nxt_s     = ST_IDLE;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // Operand, index and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= LAST_IDX;
            a_r         <= {WIDTH{1'b0}};
            b_r         <= {WIDTH{1'b0}};
            un_r        <= 1'b0;
            op_r        <= 3'b000;
            out_valid_r <= 1'b0;
            br_less_r   <= 1'b0;
            br_equal_r  <= 1'b0;
            br_taken_r  <= 1'b0;
`ifndef BRC_ITER_EARLY_EXIT_EN
            decided_r   <= 1'b0;
            pend_less_r <= 1'b0;
`endif
        end else begin
            idx_r       <= idx_nxt_s;
            a_r         <= a_nxt_s;
            b_r         <= b_nxt_s;
            un_r        <= un_nxt_s;
            op_r        <= op_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            br_less_r   <= less_nxt_s;
            br_equal_r  <= equal_nxt_s;
            br_taken_r  <= taken_nxt_s;
`ifndef BRC_ITER_EARLY_EXIT_EN
            decided_r   <= decided_nxt_s;
            pend_less_r <= pend_less_nxt_s;
`endif
        end
    end

    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = out_valid_r;
    assign br_less   = br_less_r;
    assign br_equal  = br_equal_r;
    assign br_taken  = br_taken_r;

endmodule
